// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweep checker.
//   state_t  : sweep FSM state encoding
//   num_vec  : number of vectors in an exhaustive sweep of in_w inputs
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int num_vec(input int in_w);
        return 2 ** in_w;
    endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// Settle countdown: load/decrement counter with a zero flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value loaded
//   dec        : decrement by one (ignored when already zero)
//   zero       : count is zero
module sweep_settle_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_sweep_checker.sv
// Exhaustive truth-table sweep checker. Drives every input vector from 0 to
// all-ones, waits SETTLE cycles, then compares masked DUT outputs against the
// golden outputs and counts mismatching vectors.
// Optional feature: define TRUTH_SWEEP_FIRST_FAIL_EN to capture the first
// failing vector and its masked difference; otherwise both outputs are 0.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a sweep (accepted only when idle or done)
//   chan_mask    : channels compared, latched at start
//   vec_o        : stimulus vector
//   dut_i, ref_i : DUT and golden outputs
//   busy, done   : sweep in progress / sweep complete (held until next start)
//   pass         : no mismatches, valid with done
//   err_cnt      : mismatching vector count, saturating
//   first_vec    : first failing vector
//   first_diff   : masked difference at the first failing vector
// Handshake: start is a level sampled on the rising edge; it is acted on only
// when busy=0, and done stays high until the next accepted start.
module truth_sweep_checker
    import sweep_pkg::*;
#(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 15,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OUT_W-1:0] chan_mask,
    output logic [IN_W-1:0]  vec_o,
    input  logic [OUT_W-1:0] dut_i,
    input  logic [OUT_W-1:0] ref_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IN_W:0]    err_cnt,
    output logic [IN_W-1:0]  first_vec,
    output logic [OUT_W-1:0] first_diff
);

    localparam int NUM_VEC = num_vec(IN_W);
    localparam int CNT_W   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [IN_W-1:0] LAST_VEC = IN_W'(NUM_VEC - 1);
    localparam logic [IN_W:0]   ERR_MAX  = '1;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  vec_q;
    logic [OUT_W-1:0] mask_q;
    logic [IN_W:0]    err_q;
    logic [OUT_W-1:0] diff;
    logic             fail;
    logic             last;
    logic             accept;
    logic             chk;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    // Case-inequality so an X/Z on a masked channel counts as a mismatch.
    assign diff = (dut_i ^ ref_i) & mask_q;
    assign fail = (diff !== '0);
    assign last = (vec_q == LAST_VEC);

    sweep_settle_cnt #(.W(CNT_W)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_W'(SETTLE)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // APPLY is entered with the counter loaded to SETTLE, so it lasts
    // SETTLE+1 cycles; with CHECK that gives SETTLE+2 cycles per vector.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        chk      = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_APPLY;
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            ST_APPLY: begin
                if (cnt_zero) state_d = ST_CHECK;
                else          cnt_dec = 1'b1;
            end
            ST_CHECK: begin
                chk = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_APPLY;
                    cnt_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            mask_q <= '0;
            err_q  <= '0;
        end else if (accept) begin
            vec_q  <= '0;
            mask_q <= chan_mask;
            err_q  <= '0;
        end else if (chk) begin
            if (fail && (err_q != ERR_MAX)) err_q <= err_q + 1'b1;
            // Stop on all-ones so DONE keeps the last vector applied.
            if (!last) vec_q <= vec_q + 1'b1;
        end
    end

    assign vec_o   = vec_q;
    assign err_cnt = err_q;
    assign busy    = (state_q == ST_APPLY) || (state_q == ST_CHECK);
    assign done    = (state_q == ST_DONE);
    assign pass    = done && (err_q == '0);

`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
    logic [IN_W-1:0]  fvec_q;
    logic [OUT_W-1:0] fdiff_q;

    // err_q is still zero exactly on the first failing CHECK of a sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fvec_q  <= '0;
            fdiff_q <= '0;
        end else if (accept) begin
            fvec_q  <= '0;
            fdiff_q <= '0;
        end else if (chk && fail && (err_q == '0)) begin
            fvec_q  <= vec_q;
            fdiff_q <= diff;
        end
    end

    assign first_vec  = fvec_q;
    assign first_diff = fdiff_q;
`else
    assign first_vec  = '0;
    assign first_diff = '0;
`endif

endmodule

// File: tb/tb_truth_sweep_checker.sv
module tb_truth_sweep_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- main instance: IN_W=4, OUT_W=15, SETTLE=1 ----------------
    logic        start = 1'b0;
    logic [14:0] chan_mask = '0;
    logic [3:0]  vec;
    logic [14:0] dut_v, ref_v;
    logic        busy, done, pass;
    logic [4:0]  err_cnt;
    logic [3:0]  first_vec;
    logic [14:0] first_diff;
    int          mode = 0;   // 0 clean, 1 bit3 flipped at vec 5, 2 bit3 always flipped

    truth_sweep_checker #(.IN_W(4), .OUT_W(15), .SETTLE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .chan_mask  (chan_mask),
        .vec_o      (vec),
        .dut_i      (dut_v),
        .ref_i      (ref_v),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .first_vec  (first_vec),
        .first_diff (first_diff)
    );

    always_comb begin
        ref_v = '0;
        for (int i = 0; i < 15; i++) ref_v[i] = ~vec[i % 4];
        dut_v = ref_v;
        if ((mode == 1 && vec == 4'h5) || mode == 2) dut_v = ref_v ^ 15'h0008;
    end

    // Vectors seen while busy, cleared when a start is accepted.
    logic [15:0] seen;
    always @(posedge clk) begin
        if (start && !busy) seen <= '0;
        else if (busy)      seen[vec] <= 1'b1;
    end

    // ---------------- small instances: every vector fails ----------------
    logic       start_s = 1'b0;
    logic [1:0] vec2;
    logic [3:0] ref2, dut2, fdiff2;
    logic       busy2, done2, pass2;
    logic [2:0] err2;
    logic [1:0] fvec2;

    assign ref2 = {vec2, vec2};
    assign dut2 = ~ref2;

    truth_sweep_checker #(.IN_W(2), .OUT_W(4), .SETTLE(0)) dut2_i (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s),
        .chan_mask  (4'hF),
        .vec_o      (vec2),
        .dut_i      (dut2),
        .ref_i      (ref2),
        .busy       (busy2),
        .done       (done2),
        .pass       (pass2),
        .err_cnt    (err2),
        .first_vec  (fvec2),
        .first_diff (fdiff2)
    );

    logic       vec1;
    logic [1:0] ref1, dut1, fdiff1;
    logic       busy1, done1, pass1;
    logic [1:0] err1;
    logic       fvec1;

    assign ref1 = {vec1, vec1};
    assign dut1 = ~ref1;

    truth_sweep_checker #(.IN_W(1), .OUT_W(2), .SETTLE(2)) dut1_i (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s),
        .chan_mask  (2'h3),
        .vec_o      (vec1),
        .dut_i      (dut1),
        .ref_i      (ref1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .err_cnt    (err1),
        .first_vec  (fvec1),
        .first_diff (fdiff1)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Runs one sweep on the main instance; restart_at > 0 pulses start again
    // at that cycle. cyc = rising edges from the accepting edge to done=1.
    task automatic run_main(input logic [14:0] m, input int restart_at, output int cyc);
        @(negedge clk);
        chan_mask = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_vec", 32'(vec), 32'd0);
        check("start_done", 32'(done), 32'd0);
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
        end
        start = 1'b0;
        if (!done) check("main_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_first(input string tag, input logic [3:0] fv, input logic [14:0] fd);
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
        check({tag, "_first_vec"}, 32'(first_vec), 32'(fv));
        check({tag, "_first_diff"}, 32'(first_diff), 32'(fd));
`else
        check({tag, "_first_vec"}, 32'(first_vec), 32'd0);
        check({tag, "_first_diff"}, 32'(first_diff), 32'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int cyc2, cyc1, n;
        int distinct;

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_vec", 32'(vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);

        // Clean sweep, full mask
        mode = 0;
        run_main(15'h7FFF, 0, cyc);
        check("clean_latency", 32'(cyc), 32'd48);
        check("clean_pass", 32'(pass), 32'd1);
        check("clean_err", 32'(err_cnt), 32'd0);
        check("clean_busy", 32'(busy), 32'd0);
        check("clean_last_vec", 32'(vec), 32'hF);
        distinct = 0;
        for (int i = 0; i < 16; i++) distinct += int'(seen[i]);
        check("clean_distinct", 32'(distinct), 32'd16);
        check("clean_seen_f", 32'(seen[15]), 32'd1);
        expect_first("clean", 4'h0, 15'h0000);
        repeat (3) @(negedge clk);
        check("done_held", 32'(done), 32'd1);

        // Single failure at vector 5
        mode = 1;
        run_main(15'h7FFF, 0, cyc);
        check("one_err", 32'(err_cnt), 32'd1);
        check("one_pass", 32'(pass), 32'd0);
        expect_first("one", 4'h5, 15'h0008);

        // Bit 3 always wrong, masked off
        mode = 2;
        run_main(15'h7FF7, 0, cyc);
        check("masked_pass", 32'(pass), 32'd1);
        check("masked_err", 32'(err_cnt), 32'd0);
        expect_first("masked", 4'h0, 15'h0000);

        // Bit 3 always wrong, compared
        run_main(15'h7FFF, 0, cyc);
        check("allbad_err", 32'(err_cnt), 32'd16);
        check("allbad_pass", 32'(pass), 32'd0);
        expect_first("allbad", 4'h0, 15'h0008);

        // All-zero mask
        run_main(15'h0000, 0, cyc);
        check("zmask_pass", 32'(pass), 32'd1);
        check("zmask_err", 32'(err_cnt), 32'd0);

        // start again mid-sweep is ignored
        mode = 0;
        run_main(15'h7FFF, 20, cyc);
        check("restart_latency", 32'(cyc), 32'd48);
        check("restart_pass", 32'(pass), 32'd1);

        // Small instances: every vector fails, no saturation
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n = 0; cyc2 = -1; cyc1 = -1;
        while ((!done2 || !done1) && n < 100) begin
            @(negedge clk);
            n++;
            if (done2 && cyc2 < 0) cyc2 = n;
            if (done1 && cyc1 < 0) cyc1 = n;
        end
        check("w2_latency", 32'(cyc2), 32'd8);
        check("w2_err", 32'(err2), 32'd4);
        check("w2_pass", 32'(pass2), 32'd0);
        check("w1_latency", 32'(cyc1), 32'd8);
        check("w1_err", 32'(err1), 32'd2);
        check("w1_pass", 32'(pass1), 32'd0);
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
        check("w2_first_diff", 32'(fdiff2), 32'hF);
        check("w1_first_diff", 32'(fdiff1), 32'h3);
`else
        check("w2_first_diff", 32'(fdiff2), 32'h0);
        check("w1_first_diff", 32'(fdiff1), 32'h0);
`endif

        // Asynchronous reset mid-sweep at vector 7
        mode = 1;
        @(negedge clk);
        chan_mask = 15'h7FFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (vec != 4'h7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_vec7", 32'(vec), 32'h7);
        check("vec7_err", 32'(err_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec", 32'(vec), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_pass", 32'(pass), 32'd0);
        check("arst_err", 32'(err_cnt), 32'd0);
        check("arst_first_vec", 32'(first_vec), 32'd0);
        check("arst_first_diff", 32'(first_diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        mode = 0;
        run_main(15'h7FFF, 0, cyc);
        check("resweep_latency", 32'(cyc), 32'd48);
        check("resweep_err", 32'(err_cnt), 32'd0);
        check("resweep_pass", 32'(pass), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
